i2c_config_sequencer: RTL and testbench

Sequencer that walks a register-configuration table and drives the I2C write engine one entry at a time. It performs the engine's enable/END handshake, retries entries that return a NACK, enforces a per-transaction watchdog, and reports done or error. It sits between the sensor-configuration LUT and the I2C write engine in the camera bring-up path. It is the only master of the engine's control inputs.

---
 rtl/i2c_config_sequencer.sv | 147 ++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
// i2c_config_sequencer: walks a register LUT and drives the I2C write engine,
// with NACK retry and a per-transaction watchdog.           Rev 1.0
// ============================================================================
module i2c_config_sequencer #(
  parameter int         LUT_SIZE    = 64,
  parameter int         IDX_W       = 6,
  parameter logic [7:0] SLAVE_ADDR  = 8'h21,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic [IDX_W-1:0] lut_index_o,
  input  logic [15:0]      lut_data_i,
  output logic             wr_enable_o,
  output logic [15:0]      wr_reg_data_o,
  output logic [7:0]       wr_sl_addr_o,
  output logic [7:0]       wr_byte_num_o,
  input  logic             wr_end_i,
  input  logic             wr_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_index_o
);

  localparam int               RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LUT_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ARM, S_RELEASE,
    S_WAIT_END, S_CHECK, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [15:0]      data_q, data_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic             err_q, err_d;

  // Saturating so a stuck engine can never wrap the watchdog back to zero.
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      data_q    <= '0;
      rty_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      data_q    <= data_d;
      rty_q     <= rty_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    data_d    = data_q;
    rty_d     = rty_q;
    wd_d      = wd_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && wr_end_i) begin
          err_d   = 1'b0;
          idx_d   = '0;
          rty_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        data_d  = lut_data_i;
        state_d = (lut_data_i == 16'h0000) ? S_DONE : S_ARM;
      end
      S_ARM: state_d = S_RELEASE;
      S_RELEASE: begin
        wd_d = wd_inc;
        if (wd_inc >= WD_MAX)  state_d = S_FAIL;
        else if (!wr_end_i)    state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        wd_d = wd_inc;
        if (wd_inc >= WD_MAX)  state_d = S_FAIL;
        else if (wr_end_i)     state_d = S_CHECK;
      end
      S_CHECK: begin
        // 16'hFFFF is a delay entry: its ACK status carries no meaning.
        if (data_q == 16'hFFFF || !wr_ack_i) begin
          state_d = S_NEXT;
        end else if (rty_q < RTY_MAX) begin
          rty_d   = rty_q + RTY_W'(1);
          state_d = S_ARM;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_NEXT: begin
        rty_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ARM) wd_d = '0;
    if (state_d == S_FAIL) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end
  end

  assign lut_index_o   = idx_q;
  assign wr_enable_o   = (state_q == S_ARM);
  assign wr_reg_data_o = data_q;
  assign wr_sl_addr_o  = SLAVE_ADDR;
  assign wr_byte_num_o = 8'd2;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = err_q;
  assign err_index_o   = err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_config_sequencer.sv
`default_nettype none
// Bench for i2c_config_sequencer: table vectors, hand sequences and randomized
// runs checked against a transaction-level reference model.
module tb_i2c_config_sequencer;
  localparam int LS = 8;
  localparam int IW = 3;
  localparam int MR = 3;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [IW-1:0] lut_index_o;
  logic [15:0]   lut_data_i;
  logic          wr_enable_o;
  logic [15:0]   wr_reg_data_o;
  logic [7:0]    wr_sl_addr_o;
  logic [7:0]    wr_byte_num_o;
  logic          wr_end_i;
  logic          wr_ack_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [IW-1:0] err_index_o;

  i2c_config_sequencer #(
    .LUT_SIZE(LS), .IDX_W(IW), .SLAVE_ADDR(8'h21), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .lut_index_o(lut_index_o),
    .lut_data_i(lut_data_i), .wr_enable_o(wr_enable_o), .wr_reg_data_o(wr_reg_data_o),
    .wr_sl_addr_o(wr_sl_addr_o), .wr_byte_num_o(wr_byte_num_o), .wr_end_i(wr_end_i),
    .wr_ack_i(wr_ack_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_index_o(err_index_o)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] cur_rom [LS];
  int          cur_nacks [LS];
  int          cur_hang = -1;
  int          att [LS];
  bit          eng_abort = 1'b0;
  bit          mon_en = 1'b0;
  logic [15:0] tx_data [$];
  int          tx_idx [$];
  logic [15:0] exp_data [$];
  int          exp_idx [$];

  typedef struct {
    logic [0:7][15:0] rom;
    logic [0:7][3:0]  nacks;
    bit               poke;
    int               exp_ntx;
    bit               exp_done;
    bit               exp_err;
    int               exp_eidx;
    int               exp_last;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered ROM: data valid one cycle after the index changes.
  always @(posedge clk) lut_data_i <= cur_rom[lut_index_o];

  // Write-engine model: logs every dispatch, then runs a randomly timed END handshake.
  initial begin
    int pre, hold, eidx;
    bit ebusy;
    wr_end_i = 1'b1; wr_ack_i = 1'b0; ebusy = 1'b0;
    pre = 0; hold = 0; eidx = 0;
    forever begin
      @(negedge clk);
      if (eng_abort) begin
        ebusy = 1'b0; wr_end_i = 1'b1; wr_ack_i = 1'b0;
      end else if (!ebusy) begin
        if (wr_enable_o) begin
          tx_data.push_back(wr_reg_data_o);
          tx_idx.push_back(int'(lut_index_o));
          eidx = int'(lut_index_o); ebusy = 1'b1; wr_ack_i = 1'b0;
          pre = int'($urandom_range(0, 2)); hold = int'($urandom_range(2, 6));
          if (pre == 0) wr_end_i = 1'b0;
        end
      end else if (wr_end_i) begin
        pre--;
        if (pre <= 0) wr_end_i = 1'b0;
      end else if (eidx != cur_hang) begin
        hold--;
        if (hold <= 0) begin
          wr_ack_i = (att[eidx] < cur_nacks[eidx]);
          att[eidx]++;
          wr_end_i = 1'b1;
          ebusy    = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [15:0] prev_data;
    bit          prev_end;
    prev_data = '0; prev_end = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (mon_en && done_o && error_o) check("done_error_exclusive", 32'(error_o), 0);
      if (mon_en && !prev_end && !wr_end_i && wr_reg_data_o !== prev_data)
        check("data_stable_while_engine_busy", wr_reg_data_o, prev_data);
      prev_data = wr_reg_data_o; prev_end = wr_end_i;
    end
  end

  // Reference model: expected dispatch list and outcome from the table rules.
  task automatic model_run(output int e_ntx, output bit e_done, output bit e_err,
                           output int e_eidx, output int e_last);
    int tries;
    exp_data.delete(); exp_idx.delete();
    e_done = 1'b0; e_err = 1'b0; e_eidx = 0; e_last = 0;
    for (int i = 0; i < LS; i++) begin
      e_last = i;
      if (cur_rom[i] == 16'h0000) begin e_done = 1'b1; break; end
      if (i == cur_hang) begin
        exp_data.push_back(cur_rom[i]); exp_idx.push_back(i);
        e_err = 1'b1; e_eidx = i; break;
      end
      if (cur_rom[i] == 16'hFFFF)  tries = 1;
      else if (cur_nacks[i] > MR)  tries = MR + 1;
      else                         tries = cur_nacks[i] + 1;
      repeat (tries) begin exp_data.push_back(cur_rom[i]); exp_idx.push_back(i); end
      if (cur_rom[i] != 16'hFFFF && cur_nacks[i] > MR) begin e_err = 1'b1; e_eidx = i; break; end
      if (i == LS - 1) e_done = 1'b1;
    end
    e_ntx = exp_data.size();
  endtask

  task automatic run_and_compare(input string name, input bit poke, output int g_ntx,
                                 output bit g_done, output bit g_err, output int g_eidx,
                                 output int g_last, output int t_en, output int t_err);
    int e_ntx, e_eidx, e_last, cyc, n;
    bit e_done, e_err, fin;
    model_run(e_ntx, e_done, e_err, e_eidx, e_last);
    for (int k = 0; k < LS; k++) att[k] = 0;
    tx_data.delete(); tx_idx.delete();
    g_done = 1'b0; g_err = 1'b0; t_en = -1; t_err = -1;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check({name, "_start_busy"}, busy_o, 1);
    check({name, "_start_index0"}, lut_index_o, 0);
    check({name, "_start_err_clear"}, error_o, 0);
    @(negedge clk);
    check({name, "_no_enable_before_arm"}, wr_enable_o, 0);
    cyc = 3; fin = 1'b0;
    while (!fin && cyc < 6000) begin
      @(negedge clk);
      if (cyc == 3) check({name, "_first_enable_cycle"}, wr_enable_o, 32'(cur_rom[0] != 16'h0000));
      if (wr_enable_o && t_en < 0) t_en = cyc;
      start_i = (poke && cyc == 20);
      if (done_o) begin g_done = 1'b1; fin = 1'b1; check({name, "_busy_low_at_done"}, busy_o, 0); end
      if (error_o) begin
        g_err = 1'b1; fin = 1'b1; t_err = cyc;
        check({name, "_fail_enable_low"}, wr_enable_o, 0);
        check({name, "_busy_low_at_fail"}, busy_o, 0);
      end
      cyc++;
    end
    start_i = 1'b0;
    check({name, "_finished"}, 32'(fin), 1);
    g_eidx = int'(err_index_o);
    g_last = int'(lut_index_o);
    repeat (8) @(negedge clk);
    g_ntx = tx_data.size();
    check({name, "_ntx"}, g_ntx, e_ntx);
    check({name, "_done"}, 32'(g_done), 32'(e_done));
    check({name, "_error"}, 32'(g_err), 32'(e_err));
    if (e_err) check({name, "_err_index"}, g_eidx, e_eidx);
    check({name, "_last_index"}, g_last, e_last);
    n = (g_ntx < e_ntx) ? g_ntx : e_ntx;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tx%0d_data", name, i), tx_data[i], exp_data[i]);
      check($sformatf("%s_tx%0d_index", name, i), tx_idx[i], exp_idx[i]);
    end
  endtask

  initial begin
    int g_ntx, g_eidx, g_last, t_en, t_err, cyc, r;
    bit g_done, g_err;
    vecs[0] = '{rom: {16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {8{4'd0}}, poke: 1'b0, exp_ntx: 3, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 3};
    vecs[1] = '{rom: {16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, poke: 1'b0,
                exp_ntx: 5, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 3};
    vecs[2] = '{rom: {16'h1280, 16'h1101, 16'h2233, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, poke: 1'b0,
                exp_ntx: 6, exp_done: 1'b0, exp_err: 1'b1, exp_eidx: 2, exp_last: 2};
    vecs[3] = '{rom: {16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808},
                nacks: {8{4'd0}}, poke: 1'b1, exp_ntx: 8, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 7};
    vecs[4] = '{rom: {16'h0000, 16'h1234, 16'h5678, 16'h9ABC, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {8{4'd0}}, poke: 1'b0, exp_ntx: 0, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 0};
    vecs[5] = '{rom: {16'hFFFF, 16'h0000, 16'h5678, 16'h9ABC, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, poke: 1'b0,
                exp_ntx: 1, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 1};
    vecs[6] = '{rom: {16'hA0A0, 16'h0000, 16'h5678, 16'h9ABC, 16'h1111, 16'h2222, 16'h3333, 16'h4444},
                nacks: {4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, poke: 1'b0,
                exp_ntx: 4, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 0, exp_last: 1};

    for (int i = 0; i < LS; i++) begin cur_rom[i] = 16'h0000; cur_nacks[i] = 0; att[i] = 0; end
    reset = 1'b0; start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_lut_index", lut_index_o, 0);
    check("reset_wr_enable", wr_enable_o, 0);
    check("reset_wr_reg_data", wr_reg_data_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_error", error_o, 0);
    check("reset_err_index", err_index_o, 0);
    check("const_sl_addr", wr_sl_addr_o, 8'h21);
    check("const_byte_num", wr_byte_num_o, 8'd2);
    @(negedge clk); reset = 1'b1; mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < LS; i++) begin
        cur_rom[i] = vecs[v].rom[i];
        cur_nacks[i] = int'(vecs[v].nacks[i]);
      end
      cur_hang = -1;
      run_and_compare($sformatf("vec%0d", v), vecs[v].poke, g_ntx, g_done, g_err, g_eidx, g_last, t_en, t_err);
      check($sformatf("vec%0d_tbl_ntx", v), g_ntx, vecs[v].exp_ntx);
      check($sformatf("vec%0d_tbl_done", v), 32'(g_done), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_tbl_error", v), 32'(g_err), 32'(vecs[v].exp_err));
      if (vecs[v].exp_err) check($sformatf("vec%0d_tbl_err_index", v), g_eidx, vecs[v].exp_eidx);
      check($sformatf("vec%0d_tbl_last_index", v), g_last, vecs[v].exp_last);
    end

    // Watchdog: engine never finishes entry 0.
    for (int i = 0; i < LS; i++) begin cur_rom[i] = vecs[0].rom[i]; cur_nacks[i] = 0; end
    cur_hang = 0;
    run_and_compare("watchdog", 1'b0, g_ntx, g_done, g_err, g_eidx, g_last, t_en, t_err);
    check("watchdog_latency_window", 32'((t_err - t_en) >= TO && (t_err - t_en) <= TO + 4), 1);
    check("watchdog_err_index", g_eidx, 0);
    check("watchdog_enable_low", wr_enable_o, 0);
    eng_abort = 1'b1; repeat (2) @(negedge clk); eng_abort = 1'b0;

    // Reset while entry 3 is in flight, then restart from index 0.
    for (int i = 0; i < LS; i++) begin cur_rom[i] = vecs[3].rom[i]; cur_nacks[i] = 0; att[i] = 0; end
    cur_hang = 3;
    tx_data.delete(); tx_idx.delete();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!(tx_idx.size() >= 4 && !wr_end_i) && cyc < 2000) begin @(negedge clk); #1; cyc++; end
    check("midrun_reached_entry3", tx_idx.size(), 4);
    repeat (3) @(negedge clk);
    check("midrun_busy_before_reset", busy_o, 1);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_lut_index", lut_index_o, 0);
    check("midrun_reset_wr_enable", wr_enable_o, 0);
    check("midrun_reset_wr_reg_data", wr_reg_data_o, 0);
    check("midrun_reset_busy", busy_o, 0);
    check("midrun_reset_done", done_o, 0);
    check("midrun_reset_error", error_o, 0);
    eng_abort = 1'b1; repeat (2) @(negedge clk); eng_abort = 1'b0;
    cur_hang = -1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrun_no_resume", busy_o, 0);
    mon_en = 1'b1;
    run_and_compare("after_reset", 1'b0, g_ntx, g_done, g_err, g_eidx, g_last, t_en, t_err);

    // Randomized tables and NACK patterns against the model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < LS; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 6 && i > 0)  cur_rom[i] = 16'h0000;
        else if (r < 16)     cur_rom[i] = 16'hFFFF;
        else                 cur_rom[i] = 16'($urandom_range(1, 16'hFFFE));
        r = int'($urandom_range(0, 99));
        cur_nacks[i] = (r < 70) ? 0 : (r < 85) ? 1 : (r < 92) ? 3 : (r < 96) ? 4 : 15;
      end
      cur_hang = -1;
      run_and_compare($sformatf("rand%0d", t), 1'b0, g_ntx, g_done, g_err, g_eidx, g_last, t_en, t_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
